// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard/sequencing controller for a 5-stage MIPS pipeline. Produces the
//   enables and flushes for the PC, IF/ID, ID/EX and EX/MEM(+MEM/WB) registers.
//   It handles load-use stalls, taken-branch/jump flushes and multi-cycle
//   data-memory waits. An ID/EX flush is a bubble: the decoder side zeroes
//   every ID/EX control field when idex_flush is high.
//
// Parameters
//   MEM_TIMEOUT  MEM_WAIT cycles before mem_timeout is raised (>= 2)
//   CNT_W        width of the saturating stall_count performance counter
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt       source register fields of the instruction in ID
//   id_uses_rt         the ID instruction reads rt
//   id_jump            the ID instruction is j/jal
//   ex_memread, ex_rt  a load is in EX, and its destination register
//   ex_branch_taken    a beq/bne in EX resolved as taken
//   dmem_req           MEM stage holds a valid load/store
//   dmem_ready         data memory finishes the access this cycle
//   pc_write, ifid_write, idex_write, exmem_write   register enables
//   ifid_flush, idex_flush                          register clears
//   mem_timeout        sticky flag: a memory wait reached MEM_TIMEOUT cycles
//   stall_count        cycles with pc_write=0 since reset, saturating
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              WC_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  // $0 is never a real dependency, so a load targeting it never stalls.
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          // Freeze the whole pipe; ID/EX contents are preserved, so the
          // lower-priority rules re-evaluate once the access completes.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = '0;
        end else if (ex_branch_taken) begin
          // Redirect; whatever sits in IF and ID is on the wrong path, which
          // also squashes any load-use or jump decoded in ID.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          // Hold IF/ID and PC, send a bubble down. The bubble clears
          // ex_memread next cycle, so each load causes exactly one stall.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (id_jump) begin
          ifid_flush = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        if (wait_cnt_q == WC_MAX) begin
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // While reset is asserted the pipe is held and cleared regardless of state.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end

    stall_d = (!pc_write && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl built with MEM_TIMEOUT=4, CNT_W=4.
//   Control outputs are compared as the packed vector
//   {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w}
  localparam logic [5:0] C_RUN    = 6'b110101;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_BRANCH = 6'b111111;
  localparam logic [5:0] C_LDUSE  = 6'b000111;
  localparam logic [5:0] C_JUMP   = 6'b111101;
  localparam logic [5:0] C_RESET  = 6'b001010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_jump, ex_memread, ex_branch_taken;
  logic          dmem_req, dmem_ready;
  logic          pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic          exmem_write, mem_timeout;
  logic [CW-1:0] stall_count;
  logic [5:0]    ctl;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sc   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_write     (exmem_write),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Reset pulse placed between clock edges (called just after a rising edge).
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_sc = 0;
  endtask

  // Load in EX writing $8, ID instruction reading $8 through rt.
  task automatic set_load_use();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd9; id_rt = 5'd8; id_uses_rt = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    #2;
    check("reset_ctl", 16'(ctl), 16'(C_RESET));
    check("reset_sc", 16'(stall_count), 16'd0);
    check("reset_to", 16'(mem_timeout), 16'd0);
    #10 rst_n = 1'b1;   // t=12, between edges
    tick();

    // Plain running
    #1 check("run_idle", 16'(ctl), 16'(C_RUN));
    tick();

    // Load-use via rt: one stall, then the bubble clears ex_memread
    set_load_use();
    #1 check("lduse_rt", 16'(ctl), 16'(C_LDUSE));
    tick(); exp_sc++;
    check("lduse_sc", 16'(stall_count), 16'(exp_sc));
    ex_memread = 1'b0;
    #1 check("lduse_after_bubble", 16'(ctl), 16'(C_RUN));
    tick();

    // Same registers but ID does not read rt: no stall
    set_load_use(); id_uses_rt = 1'b0;
    #1 check("nouse_rt", 16'(ctl), 16'(C_RUN));
    tick();

    // Load-use via rs
    ex_rt = 5'd9;
    #1 check("lduse_rs", 16'(ctl), 16'(C_LDUSE));
    tick(); exp_sc++;

    // Load to $0 never stalls
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1 check("lduse_r0", 16'(ctl), 16'(C_RUN));
    tick();
    check("r0_sc", 16'(stall_count), 16'(exp_sc));

    // Taken branch squashes a load-use in ID
    set_load_use(); ex_branch_taken = 1'b1; id_jump = 1'b1;
    #1 check("branch_over_lduse", 16'(ctl), 16'(C_BRANCH));
    tick();
    check("branch_sc", 16'(stall_count), 16'(exp_sc));

    // Jump alone, then load-use beats jump
    idle_inputs(); id_jump = 1'b1;
    #1 check("jump", 16'(ctl), 16'(C_JUMP));
    tick();
    set_load_use();
    #1 check("lduse_over_jump", 16'(ctl), 16'(C_LDUSE));
    tick(); exp_sc++;

    // Zero-wait memory access does not stall
    idle_inputs(); dmem_req = 1'b1; dmem_ready = 1'b1;
    #1 check("mem_zero_wait", 16'(ctl), 16'(C_RUN));
    tick();
    check("zero_wait_sc", 16'(stall_count), 16'(exp_sc));

    // Memory wait: three frozen cycles (RUN detect, MEM_WAIT, MEM_WAIT+ready);
    // a taken branch held during the freeze must not leak through.
    dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1 check("mem_detect", 16'(ctl), 16'(C_FREEZE));
    tick(); exp_sc++;
    dmem_req = 1'b0;
    #1 check("mem_wait1", 16'(ctl), 16'(C_FREEZE));
    tick(); exp_sc++;
    dmem_ready = 1'b1;
    #1 check("mem_wait_ready", 16'(ctl), 16'(C_FREEZE));
    tick(); exp_sc++;
    dmem_ready = 1'b0;
    #1 check("mem_resume_branch", 16'(ctl), 16'(C_BRANCH));
    check("mem_sc", 16'(stall_count), 16'(exp_sc));
    check("mem_no_timeout", 16'(mem_timeout), 16'd0);

    // Timeout: after reset, ready low for RUN + 9 MEM_WAIT cycles, then ready
    tick();
    pulse_reset();
    idle_inputs();
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); exp_sc++;                          // RUN detect edge
    for (int i = 1; i <= 9; i++) begin
      tick(); exp_sc++;                        // MEM_WAIT edge i
      if (i == 3) check("to_before", 16'(mem_timeout), 16'd0);
      if (i == 4) check("to_set", 16'(mem_timeout), 16'd1);
    end
    check("to_still_frozen", 16'(ctl), 16'(C_FREEZE));
    dmem_ready = 1'b1;
    tick(); exp_sc++;
    idle_inputs();
    #1 check("to_resume", 16'(ctl), 16'(C_RUN));
    check("to_sticky", 16'(mem_timeout), 16'd1);
    check("to_sc", 16'(stall_count), 16'(exp_sc));

    // Async reset in the middle of MEM_WAIT
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check("arst_ctl", 16'(ctl), 16'(C_RESET));
    check("arst_sc", 16'(stall_count), 16'd0);
    check("arst_to", 16'(mem_timeout), 16'd0);
    idle_inputs();
    #1 rst_n = 1'b1;
    exp_sc = 0;
    tick();
    #1 check("arst_run", 16'(ctl), 16'(C_RUN));
    check("arst_sc_hold", 16'(stall_count), 16'd0);

    // Saturation: 20 consecutive load-use stall cycles on a 4-bit counter
    set_load_use();
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      if (i == 14) check("sat_14", 16'(stall_count), 16'd14);
    end
    check("sat_15", 16'(stall_count), 16'd15);
    check("sat_model", 16'(stall_count), 16'(exp_sc));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
